// File: rtl/line_mem_responder_if.sv
// Line-transfer handshake between the cache's memory port (master) and the
// main-memory responder (slave): one line request, then a burst of 32-bit beats.
interface line_mem_responder_if;
    logic        req_valid;
    logic        req_rw;
    logic [31:0] req_addr;
    logic        req_ready;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [31:0] rdata;
    logic        rvalid;
    logic        done;
    logic [31:0] req_count;

    modport master (
        output req_valid, req_rw, req_addr, wdata, wvalid,
        input  req_ready, wready, rdata, rvalid, done, req_count
    );

    modport slave (
        input  req_valid, req_rw, req_addr, wdata, wvalid,
        output req_ready, wready, rdata, rvalid, done, req_count
    );
endinterface

// File: rtl/line_mem_responder.sv
// Main-memory model answering line refills and writebacks: accepts one request,
// waits LATENCY cycles, then streams or absorbs LINE_WORDS beats and pulses done.
module line_mem_responder #(
    parameter int ADDR_W     = 10,
    parameter int LINE_WORDS = 4,
    parameter int LATENCY    = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    line_mem_responder_if.slave  bus
);
    localparam int              BEAT_W    = $clog2(LINE_WORDS);
    localparam int              LINE_W    = ADDR_W - BEAT_W;
    localparam logic [7:0]      LAT       = 8'(LATENCY);
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WAIT   = 3'd1,
        RBURST = 3'd2,
        WBURST = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t              state_r, state_s;
    logic [LINE_W-1:0]   line_r, line_s;
    logic                rw_r, rw_s;
    logic [BEAT_W-1:0]   beat_r, beat_s;
    logic [7:0]          lat_r, lat_s;
    logic [31:0]         count_r, count_s;
    logic                wr_en_s;
    logic [31:0]         mem_r [0:(1 << ADDR_W) - 1];
    logic [31:0]         rdata_r;
    logic                rvalid_r, wready_r, req_ready_r, done_r;
    logic                addr_unused_s;

    assign addr_unused_s = ^{bus.req_addr[31:ADDR_W+2], bus.req_addr[BEAT_W+1:0]};

    // State and transfer-context registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= IDLE;
            line_r  <= '0;
            rw_r    <= 1'b0;
            beat_r  <= '0;
            lat_r   <= 8'd0;
            count_r <= 32'd0;
        end else begin
            state_r <= state_s;
            line_r  <= line_s;
            rw_r    <= rw_s;
            beat_r  <= beat_s;
            lat_r   <= lat_s;
            count_r <= count_s;
        end
    end

    // Next-state logic; beat index wraps naturally inside the line
    always_comb begin
        state_s = state_r;
        line_s  = line_r;
        rw_s    = rw_r;
        beat_s  = beat_r;
        lat_s   = lat_r;
        count_s = count_r;
        wr_en_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.req_valid && req_ready_r) begin
                    line_s  = bus.req_addr[ADDR_W+1:BEAT_W+2];
                    rw_s    = bus.req_rw;
                    beat_s  = '0;
                    lat_s   = LAT;
                    count_s = count_r + 32'd1;
                    if (LAT == 8'd0) begin
                        state_s = bus.req_rw ? WBURST : RBURST;
                    end else begin
                        state_s = WAIT;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                lat_s = lat_r - 8'd1;
                if (lat_r <= 8'd1) begin
                    state_s = rw_r ? WBURST : RBURST;
                end else begin
                    state_s = WAIT;
                end
            end
            RBURST: begin
                beat_s = beat_r + BEAT_W'(1);
                if (beat_r == LAST_BEAT) begin
                    state_s = DONE;
                end else begin
                    state_s = RBURST;
                end
            end
            WBURST: begin
                if (bus.wvalid) begin
                    wr_en_s = 1'b1;
                    beat_s  = beat_r + BEAT_W'(1);
                    if (beat_r == LAST_BEAT) begin
                        state_s = DONE;
                    end else begin
                        state_s = WBURST;
                    end
                end else begin
                    state_s = WBURST;
                end
            end
            DONE: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Storage write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            mem_r[{line_r, beat_r}] <= bus.wdata;
        end
    end

    // Registered outputs decoded from the upcoming state, so they align with it
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            req_ready_r <= 1'b0;
            rvalid_r    <= 1'b0;
            wready_r    <= 1'b0;
            done_r      <= 1'b0;
            rdata_r     <= 32'd0;
        end else begin
            req_ready_r <= (state_s == IDLE);
            rvalid_r    <= (state_s == RBURST);
            wready_r    <= (state_s == WBURST);
            done_r      <= (state_s == DONE);
            rdata_r     <= (state_s == RBURST) ? mem_r[{line_s, beat_s}] : 32'd0;
        end
    end

    assign bus.req_ready = req_ready_r;
    assign bus.rvalid    = rvalid_r;
    assign bus.wready    = wready_r;
    assign bus.done      = done_r;
    assign bus.rdata     = rdata_r;
    assign bus.req_count = count_r;
endmodule

// File: tb/tb_line_mem_responder.sv
// Self-checking bench for line_mem_responder: read-data scoreboard, cycle-exact
// handshake timing, write stalls, aliasing, mid-burst reset and back-to-back requests.
module tb_line_mem_responder;
    localparam int LAT = 4;
    localparam int LW  = 4;

    logic clk;
    logic rstn;
    int   tests_run;
    int   tests_failed;
    int   exp_count;
    logic [31:0] model_mem [0:1023];
    logic [31:0] exp_q [$];

    line_mem_responder_if bus ();
    line_mem_responder_if bus0 ();

    line_mem_responder #(.ADDR_W(10), .LINE_WORDS(LW), .LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn), .bus(bus)
    );

    line_mem_responder #(.ADDR_W(10), .LINE_WORDS(LW), .LATENCY(0)) dut0 (
        .clk(clk), .rstn(rstn), .bus(bus0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string tag);
        for (int k = 0; k < 50 && bus.req_ready !== 1'b1; k++) tick();
        tests_run++;
        if (bus.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_ready_timeout: req_ready=%b required 1", tag, bus.req_ready);
        end
    endtask

    task automatic run_read(input logic [31:0] addr, input string tag);
        int base;
        logic [31:0] got;
        base = int'(addr[11:2]) & ~3;
        wait_ready(tag);
        for (int b = 0; b < LW; b++) exp_q.push_back(model_mem[base + b]);
        bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = addr;
        tick();
        bus.req_valid = 1'b0;
        exp_count++;
        for (int o = 0; o <= LAT + LW; o++) begin
            tests_run++;
            if ({bus.rvalid, bus.done, bus.req_ready} !==
                {1'(o >= LAT && o < LAT + LW), 1'(o == LAT + LW), 1'b0}) begin
                tests_failed++;
                $display("FAIL %s_timing off=%0d: rvalid/done/ready=%b%b%b required %b%b0", tag, o,
                         bus.rvalid, bus.done, bus.req_ready, o >= LAT && o < LAT + LW, o == LAT + LW);
            end
            if (bus.rvalid === 1'b1 && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                tests_run++;
                if (bus.rdata !== got) begin
                    tests_failed++;
                    $display("FAIL %s_rdata off=%0d: got %h required %h", tag, o, bus.rdata, got);
                end
            end
            tick();
        end
        tests_run++;
        if (exp_q.size() != 0 || bus.req_ready !== 1'b1 || bus.req_count !== 32'(exp_count)) begin
            tests_failed++;
            $display("FAIL %s_end: left=%0d ready=%b count=%0d required 0 1 %0d", tag,
                     exp_q.size(), bus.req_ready, bus.req_count, exp_count);
        end
        exp_q.delete();
    endtask

    task automatic run_write(input logic [31:0] addr, input logic [31:0] data [4],
                             input logic [15:0] pat, input int plen, input string tag);
        int base;
        int beat;
        base = int'(addr[11:2]) & ~3;
        wait_ready(tag);
        bus.req_valid = 1'b1; bus.req_rw = 1'b1; bus.req_addr = addr;
        tick();
        bus.req_valid = 1'b0;
        exp_count++;
        // wvalid during the latency window must be ignored
        bus.wvalid = 1'b1; bus.wdata = 32'hDEAD_BEEF;
        for (int o = 0; o < LAT; o++) begin
            tests_run++;
            if (bus.wready !== 1'b0) begin
                tests_failed++;
                $display("FAIL %s_wait_wready off=%0d: got %b required 0", tag, o, bus.wready);
            end
            tick();
        end
        beat = 0;
        for (int i = 0; i < plen; i++) begin
            tests_run++;
            if ({bus.wready, bus.done} !== 2'b10) begin
                tests_failed++;
                $display("FAIL %s_burst cyc=%0d: wready/done=%b%b required 10", tag, i, bus.wready, bus.done);
            end
            bus.wvalid = pat[i];
            bus.wdata  = pat[i] ? data[beat] : (32'hBAD0_0000 | 32'(i));
            if (pat[i]) begin
                model_mem[base + beat] = data[beat];
                beat++;
            end
            tick();
        end
        bus.wvalid = 1'b0;
        tests_run++;
        if ({bus.wready, bus.done} !== 2'b01) begin
            tests_failed++;
            $display("FAIL %s_done: wready/done=%b%b required 01", tag, bus.wready, bus.done);
        end
        tick();
        tests_run++;
        if ({bus.done, bus.req_ready} !== 2'b01 || bus.req_count !== 32'(exp_count)) begin
            tests_failed++;
            $display("FAIL %s_idle: done/ready=%b%b count=%0d required 01 %0d", tag,
                     bus.done, bus.req_ready, bus.req_count, exp_count);
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        bus.req_valid = 1'b0; bus.req_rw = 1'b0; bus.req_addr = 32'd0; bus.wdata = 32'd0; bus.wvalid = 1'b0;
        bus0.req_valid = 1'b0; bus0.req_rw = 1'b0; bus0.req_addr = 32'd0; bus0.wdata = 32'd0; bus0.wvalid = 1'b0;
        #2;
        tick();
        tests_run++;
        if ({bus.req_ready, bus.wready, bus.rvalid, bus.done} !== 4'b0000 ||
            bus.rdata !== 32'd0 || bus.req_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL reset_state: ready/wready/rvalid/done=%b%b%b%b rdata=%h count=%0d required 0000 0 0",
                     bus.req_ready, bus.wready, bus.rvalid, bus.done, bus.rdata, bus.req_count);
        end
        rstn = 1'b1;
        bus.wvalid = 1'b1; bus.wdata = 32'h5555_5555;
        tick();
        tests_run++;
        if ({bus.req_ready, bus.wready} !== 2'b10) begin
            tests_failed++;
            $display("FAIL reset_release: ready/wready=%b%b required 10", bus.req_ready, bus.wready);
        end
        tick();
        bus.wvalid = 1'b0;
    endtask

    task automatic test_read_zero();
        run_read(32'h0000_0010, "read_zero");
    endtask

    task automatic test_write_continuous();
        logic [31:0] d [4];
        d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
        run_write(32'h0000_0024, d, 16'h000F, 4, "write_cont");
    endtask

    task automatic test_write_stall();
        logic [31:0] d [4];
        d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3};
        run_write(32'h0000_0044, d, 16'h0059, 7, "write_stall");
    endtask

    task automatic test_readback();
        run_read(32'h0000_0020, "readback");
        run_read(32'h0000_1020, "alias");
        run_read(32'h0000_004C, "readback_stall");
        run_read(32'h0000_0000, "idle_wvalid_ignored");
    endtask

    task automatic test_reset_midburst();
        int seen_done;
        seen_done = 0;
        wait_ready("rst_mid");
        bus.req_valid = 1'b1; bus.req_rw = 1'b0; bus.req_addr = 32'h0000_0020;
        tick();
        bus.req_valid = 1'b0;
        for (int o = 0; o <= LAT; o++) tick();
        tests_run++;
        if (bus.rvalid !== 1'b1 || bus.rdata !== model_mem[9]) begin
            tests_failed++;
            $display("FAIL rst_mid_beat2: rvalid=%b rdata=%h required 1 %h", bus.rvalid, bus.rdata, model_mem[9]);
        end
        rstn = 1'b0;
        #1;
        exp_count = 0;
        tests_run++;
        if ({bus.rvalid, bus.req_ready, bus.done} !== 3'b000 || bus.req_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_abort: rvalid/ready/done=%b%b%b count=%0d required 000 0",
                     bus.rvalid, bus.req_ready, bus.done, bus.req_count);
        end
        tick();
        tick();
        rstn = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (bus.done === 1'b1) seen_done++;
            tick();
        end
        tests_run++;
        if (seen_done != 0 || bus.req_ready !== 1'b1 || bus.req_count !== 32'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_after: done_seen=%0d ready=%b count=%0d required 0 1 0",
                     seen_done, bus.req_ready, bus.req_count);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] got;
        tests_run++;
        if (bus0.req_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL b2b_start_ready: got %b required 1", bus0.req_ready);
        end
        for (int b = 0; b < LW; b++) exp_q.push_back(32'd0);
        bus0.req_valid = 1'b1; bus0.req_rw = 1'b0; bus0.req_addr = 32'h0000_0030;
        tick();
        for (int o = 0; o <= 10; o++) begin
            if (o == 5) for (int b = 0; b < LW; b++) exp_q.push_back(32'd0);
            if (o == 6) bus0.req_valid = 1'b0;
            tests_run++;
            if ({bus0.rvalid, bus0.done, bus0.req_ready} !==
                {1'(o <= 3 || (o >= 6 && o <= 9)), 1'(o == 4 || o == 10), 1'(o == 5)}) begin
                tests_failed++;
                $display("FAIL b2b_timing off=%0d: rvalid/done/ready=%b%b%b", o,
                         bus0.rvalid, bus0.done, bus0.req_ready);
            end
            if (bus0.rvalid === 1'b1 && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                tests_run++;
                if (bus0.rdata !== got) begin
                    tests_failed++;
                    $display("FAIL b2b_rdata off=%0d: got %h required %h", o, bus0.rdata, got);
                end
            end
            tick();
        end
        tests_run++;
        if (bus0.req_count !== 32'd2 || exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL b2b_count: count=%0d left=%0d required 2 0", bus0.req_count, exp_q.size());
        end
        exp_q.delete();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        exp_count    = 0;
        for (int i = 0; i < 1024; i++) model_mem[i] = 32'd0;
        test_reset();
        test_read_zero();
        test_write_continuous();
        test_write_stall();
        test_readback();
        test_reset_midburst();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
